// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder/subtractor. One full-adder cell and a registered carry
// process the operands LSB-first, one bit per clock. Area is traded for
// latency: an operation takes WIDTH RUN cycles plus one DONE cycle.
//
// Parameters
//   WIDTH  operand/result width in bits (1..64)
//
// Ports
//   clk    clock; all state updates on the rising edge
//   rst    synchronous active-high reset; overrides every other input
//   start  request; sampled only in IDLE or DONE
//   a, b   operands; captured on an accepted start
//   cin    carry-in for addition; ignored when sub=1
//   sub    0: a + b + cin, 1: a - b
//   busy   high while the operation is in flight (RUN)
//   done   one-cycle pulse when a result has just been loaded
//   sum    result of the last completed operation
//   cout   carry out of bit WIDTH-1 (in subtract mode 1 = no borrow)
//   ovf    signed overflow (carry into MSB xor carry out of MSB)
// ---------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // Bit counter needs at least one bit even for WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;       // operand A, shifted right each RUN cycle
  logic [WIDTH-1:0] r_b;       // operand B (or ~B when subtracting)
  logic             r_c;       // running carry
  logic [CW-1:0]    r_cnt;     // index of the bit being processed
  logic [WIDTH-1:0] r_res;     // partial result, filled from the MSB side
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_c_next;
  logic [WIDTH-1:0] w_res_shift;

  // Full-adder cell on the current LSBs.
  assign w_s      = r_a[0] ^ r_b[0] ^ r_c;
  assign w_c_next = (r_a[0] & r_b[0]) | (r_b[0] & r_c) | (r_a[0] & r_c);

  // New bit enters at the MSB; after WIDTH shifts bit 0 holds the first sum
  // bit. Written as a widened shift so the same expression covers WIDTH=1.
  assign w_res_shift = WIDTH'({w_s, r_res} >> 1);

  assign w_last = (r_cnt == LAST_BIT);

  // -------------------------------------------------------------------------
  // Next-state and handshake outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        // A start here chains straight into the next operation.
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_res  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + 1, so the carry seeds to 1 and cin is unused.
      r_a   <= a;
      r_b   <= sub ? ~b : b;
      r_c   <= sub ? 1'b1 : cin;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_c   <= w_c_next;
      r_cnt <= r_cnt + CW'(1);
      r_res <= w_res_shift;
      if (w_last) begin
        // r_c still holds the carry into the MSB on this edge.
        r_sum  <= w_res_shift;
        r_cout <= w_c_next;
        r_ovf  <= r_c ^ w_c_next;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
